// File: rtl/fft_oflow_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : fft_oflow_pkg                                         |
// | Purpose  : Shared widths, status-word layout and FSM states for  |
// |            the FFT overflow-statistics monitor.                  |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package fft_oflow_pkg;

  // Default parameter widths
  localparam int DEF_WIN_W = 20;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_SEQ_W = 12;

  // Status word layout; bits [29:28] are always zero
  localparam int STICKY_BIT = 31;
  localparam int VALID_BIT  = 30;
  localparam int SEQ_MSB    = 27;
  localparam int SEQ_LSB    = 16;
  localparam int CNT_MSB    = 15;
  localparam int CNT_LSB    = 0;

  // Monitor control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : sat_counter                                           |
// | Purpose  : Saturating accumulator with increment request, update |
// |            enable and synchronous zero. Exposes the saturated    |
// |            next value so the caller can latch it the same cycle. |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module sat_counter
  import fft_oflow_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         inc,
  output logic [W-1:0] acc_nxt
);

  logic [W-1:0] r_count;

  // Pin at all-ones instead of wrapping back to zero
  assign acc_nxt = (inc && !(&r_count)) ? r_count + 1'b1 : r_count;

  // Accumulator register; zero has priority over update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= acc_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fft_oflow_monitor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : fft_oflow_monitor                                     |
// | Purpose  : Counts FFT frames containing an overflow over a       |
// |            programmable window of frames and latches a 32-bit    |
// |            summary word (sticky, valid, sequence, count).        |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module fft_oflow_monitor
  import fft_oflow_pkg::*;
#(
  parameter int WIN_W = DEF_WIN_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int SEQ_W = DEF_SEQ_W
) (
  input  logic             user_clk,
  input  logic             user_rst_n,
  input  logic             fft_sync,
  input  logic             fft_oflow,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIN_W-1:0] win_frames,
  output logic [31:0]      status_out,
  output logic             win_done
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_clear_prev;
  logic               w_clear_edge;
  logic [WIN_W-1:0]   r_frame_cnt;
  logic [WIN_W-1:0]   w_frame_cnt_nxt;
  logic [WIN_W-1:0]   r_win_len;
  logic [WIN_W-1:0]   w_win_len_sample;
  logic               r_frame_hit;
  logic               w_ctr_clr;
  logic               w_ctr_en;
  logic               w_latch;
  logic               w_arm_start;
  logic [CNT_W-1:0]   w_acc_nxt;
  logic               r_sticky;
  logic               r_valid;
  logic [SEQ_W-1:0]   r_seq;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_win_done;

  assign w_clear_edge     = clear & ~r_clear_prev;
  assign w_frame_cnt_nxt  = r_frame_cnt + 1'b1;
  // A zero window length would never terminate, so it behaves as one frame
  assign w_win_len_sample = (win_frames == '0) ? WIN_W'(1) : win_frames;

  // Overflow-frame accumulator for the window in progress
  sat_counter #(
    .W (CNT_W)
  ) u_oflow_cnt (
    .clk     (user_clk),
    .rst_n   (user_rst_n),
    .clr     (w_ctr_clr),
    .en      (w_ctr_en),
    .inc     (r_frame_hit),
    .acc_nxt (w_acc_nxt)
  );

  // State register plus previous clear level for edge detection
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_state      <= ST_IDLE;
      r_clear_prev <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_clear_prev <= clear;
    end
  end

  // Next state and per-cycle control; clear edge outranks enable, which outranks counting
  always_comb begin
    w_state_nxt = r_state;
    w_ctr_clr   = 1'b0;
    w_ctr_en    = 1'b0;
    w_latch     = 1'b0;
    w_arm_start = 1'b0;
    if (w_clear_edge) begin
      // Only an already-running monitor re-arms; a clear while idle stays idle
      w_state_nxt = (r_state != ST_IDLE && enable) ? ST_ARM : ST_IDLE;
      w_ctr_clr   = 1'b1;
    end else if (!enable) begin
      w_state_nxt = ST_IDLE;
      w_ctr_clr   = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_ARM;
          w_ctr_clr   = 1'b1;
        end
        ST_ARM: begin
          w_ctr_clr = 1'b1;
          if (fft_sync) begin
            w_state_nxt = ST_COUNT;
            w_arm_start = 1'b1;
          end
        end
        ST_COUNT: begin
          if (fft_sync) begin
            if (w_frame_cnt_nxt == r_win_len) begin
              w_latch   = 1'b1;
              w_ctr_clr = 1'b1;
            end else begin
              w_ctr_en  = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_ctr_clr   = 1'b1;
        end
      endcase
    end
  end

  // Frame counter and window length; the length is only resampled at window starts
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_frame_cnt <= '0;
      r_win_len   <= '0;
    end else begin
      if (w_ctr_clr) begin
        r_frame_cnt <= '0;
      end else if (w_ctr_en) begin
        r_frame_cnt <= w_frame_cnt_nxt;
      end
      if (w_arm_start || w_latch) begin
        r_win_len <= w_win_len_sample;
      end
    end
  end

  // Per-frame overflow flag; a sync cycle already belongs to the new frame
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_frame_hit <= 1'b0;
    end else if (w_clear_edge || !enable || r_state == ST_IDLE) begin
      r_frame_hit <= 1'b0;
    end else if (fft_sync) begin
      r_frame_hit <= fft_oflow;
    end else if (r_state == ST_COUNT) begin
      r_frame_hit <= r_frame_hit | fft_oflow;
    end
  end

  // Summary fields change only on a window latch or a clear edge
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_sticky   <= 1'b0;
      r_valid    <= 1'b0;
      r_seq      <= '0;
      r_cnt      <= '0;
      r_win_done <= 1'b0;
    end else begin
      r_win_done <= w_latch;
      if (w_clear_edge) begin
        r_sticky <= 1'b0;
        r_valid  <= 1'b0;
        r_seq    <= '0;
        r_cnt    <= '0;
      end else if (w_latch) begin
        r_sticky <= r_sticky | (w_acc_nxt != '0);
        r_valid  <= 1'b1;
        r_seq    <= r_seq + 1'b1;
        r_cnt    <= w_acc_nxt;
      end
    end
  end

  // Pack the registered fields into the status word
  always_comb begin
    status_out                  = '0;
    status_out[STICKY_BIT]      = r_sticky;
    status_out[VALID_BIT]       = r_valid;
    status_out[SEQ_MSB:SEQ_LSB] = r_seq;
    status_out[CNT_MSB:CNT_LSB] = r_cnt;
  end

  assign win_done = r_win_done;

endmodule
`default_nettype wire

// File: tb/tb_fft_oflow_monitor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_fft_oflow_monitor                                  |
// | Purpose  : Scoreboard bench for fft_oflow_monitor: a frame-list  |
// |            reference model queues expected window words, a       |
// |            monitor pops them on win_done.                        |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_fft_oflow_monitor;

  logic        user_clk   = 1'b0;
  logic        user_rst_n = 1'b0;
  logic        fft_sync   = 1'b0;
  logic        fft_oflow  = 1'b0;
  logic        enable     = 1'b0;
  logic        clear      = 1'b0;
  logic [19:0] win_frames = 20'd4;
  logic [31:0] status_out;
  logic        win_done;

  int checks   = 0;
  int failures = 0;

  fft_oflow_monitor dut (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .fft_sync   (fft_sync),
    .fft_oflow  (fft_oflow),
    .enable     (enable),
    .clear      (clear),
    .win_frames (win_frames),
    .status_out (status_out),
    .win_done   (win_done)
  );

  // 10 ns clock
  initial forever #5 user_clk = ~user_clk;

  // Reference model: a running monitor collects one flag per finished frame
  bit          m_active   = 1'b0;
  bit          m_counting = 1'b0;
  bit          m_hit      = 1'b0;
  bit          m_prev_clr = 1'b0;
  bit          m_sticky   = 1'b0;
  bit          m_valid    = 1'b0;
  logic [11:0] m_seq      = '0;
  logic [15:0] m_cnt      = '0;
  int unsigned m_len      = 1;
  bit          m_flags[$];
  logic [31:0] exp_status = '0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] pack_word();
    return {m_sticky, m_valid, 2'b00, m_seq, m_cnt};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_counting = 0; m_hit = 0; m_prev_clr = 0;
    m_sticky = 0; m_valid = 0; m_seq = '0; m_cnt = '0;
    m_flags.delete();
    exp_q.delete();
    exp_status = '0;
  endtask

  task automatic model_step();
    bit          edge_c;
    int unsigned n;
    edge_c     = clear && !m_prev_clr;
    m_prev_clr = clear;
    if (edge_c) begin
      m_sticky = 0; m_valid = 0; m_seq = '0; m_cnt = '0;
      m_flags.delete(); m_hit = 0; m_counting = 0;
      m_active = m_active && enable;
    end else if (!enable) begin
      m_active = 0; m_counting = 0; m_hit = 0;
      m_flags.delete();
    end else if (!m_active) begin
      m_active = 1;
    end else if (!m_counting) begin
      if (fft_sync) begin
        m_counting = 1;
        m_len      = (win_frames == 0) ? 1 : win_frames;
        m_hit      = fft_oflow;
      end
    end else if (fft_sync) begin
      m_flags.push_back(m_hit);
      m_hit = fft_oflow;
      if (m_flags.size() == int'(m_len)) begin
        n = 0;
        foreach (m_flags[i]) n += m_flags[i];
        m_cnt    = (n > 65535) ? 16'hFFFF : n[15:0];
        m_valid  = 1;
        m_seq    = m_seq + 12'd1;
        m_sticky = m_sticky | (m_cnt != 0);
        exp_q.push_back(pack_word());
        m_flags.delete();
        m_len = (win_frames == 0) ? 1 : win_frames;
      end
    end else begin
      m_hit = m_hit | fft_oflow;
    end
    exp_status = pack_word();
  endtask

  // Model runs on the same edges as the DUT
  initial forever begin
    @(posedge user_clk or negedge user_rst_n);
    if (!user_rst_n) model_reset();
    else             model_step();
  end

  // Monitor: pops expected window words whenever win_done is due or seen
  initial forever begin
    logic [31:0] e;
    bit          due;
    @(negedge user_clk);
    if (user_rst_n === 1'b1) begin
      due = (exp_q.size() != 0);
      chk("win_done", {31'b0, win_done}, {31'b0, due});
      if (due) begin
        e = exp_q.pop_front();
        if (win_done) chk("window_word", status_out, e);
      end
      chk("status_track", status_out, exp_status);
    end
  end

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  task automatic cyc(input bit sy, input bit of);
    fft_sync  = sy;
    fft_oflow = of;
    @(negedge user_clk);
  endtask

  // n non-sync cycles; mode 0 clean, 1 overflow on first cycle, 2 overflow on all
  task automatic body(input int n, input int mode);
    for (int i = 0; i < n; i++) cyc(1'b0, (mode == 2) || (mode == 1 && i == 0));
  endtask

  initial begin
    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      enable = 1'($urandom); clear = 1'($urandom);
      fft_sync = 1'($urandom); fft_oflow = 1'($urandom);
      win_frames = 20'($urandom);
      @(negedge user_clk);
    end
    chk("reset_status", status_out, 32'h0);
    chk("reset_done", {31'b0, win_done}, 32'h0);
    enable = 0; clear = 0; fft_sync = 0; fft_oflow = 0; win_frames = 20'd4;
    user_rst_n = 1'b1;
    cyc(0, 0);

    // Basic window: 4 frames, overflow in frames 1 and 3
    enable = 1;
    cyc(0, 0);
    cyc(1, 0); body(2, 0);
    cyc(1, 0); body(2, 1);
    cyc(1, 0); body(2, 0);
    cyc(1, 0); body(2, 1);
    cyc(1, 0);
    chk("basic_word", status_out, 32'hC001_0002);
    chk("basic_done", {31'b0, win_done}, 32'h1);
    body(1, 0);
    chk("basic_done_single", {31'b0, win_done}, 32'h0);
    body(1, 0);

    // Sticky retention with a clean window
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0); body(2, 0);
    end
    win_frames = 20'd1;
    cyc(1, 0);
    chk("sticky_word", status_out, 32'hC002_0000);

    // Frame attribution with one-frame windows
    body(5, 2);
    cyc(1, 1);
    chk("attr_multi", status_out, 32'hC003_0001);
    body(2, 0);
    cyc(1, 0);
    chk("attr_sync_cycle", status_out, 32'hC004_0001);

    // Clear coincident with a window-ending sync
    body(2, 0);
    clear = 1;
    cyc(1, 0);
    chk("clear_word", status_out, 32'h0);
    chk("clear_no_done", {31'b0, win_done}, 32'h0);
    cyc(0, 0);
    cyc(1, 0);
    body(1, 1);
    clear = 0;
    cyc(1, 0);
    chk("after_clear", status_out, 32'hC001_0001);

    // Zero window length behaves as one frame
    win_frames = 20'd0;
    for (int k = 2; k <= 4; k++) begin
      body(1, 0);
      cyc(1, 0);
      chk("win_zero_seq", status_out, 32'hC000_0000 | (32'(k) << 16));
    end

    // Saturation: 70000 overflowing frames
    win_frames = 20'd70000;
    body(1, 0);
    cyc(1, 1);
    chk("sat_start", status_out, 32'hC005_0000);
    for (int i = 0; i < 70000; i++) begin
      cyc(1, 1);
      if (i == 0) win_frames = 20'd4;
    end
    chk("sat_word", status_out, 32'hC006_FFFF);

    // Enable dropped mid-window
    body(2, 0);
    cyc(1, 1);
    body(1, 0);
    enable = 0;
    cyc(0, 0);
    cyc(0, 1);
    cyc(1, 1);
    chk("enable_drop_word", status_out, 32'hC006_FFFF);
    chk("enable_drop_done", {31'b0, win_done}, 32'h0);
    enable = 1;

    // Randomized traffic checked by the scoreboard
    for (int i = 0; i < 3000; i++) begin
      bit en_n;
      bit sy;
      en_n = enable;
      if (enable && $urandom_range(0, 299) == 0) en_n = 0;
      else if (!enable && $urandom_range(0, 4) == 0) en_n = 1;
      sy = ($urandom_range(0, 3) == 0);
      if (en_n != enable) sy = 0;
      if ($urandom_range(0, 199) == 0) clear = 1;
      else if ($urandom_range(0, 9) == 0) clear = 0;
      if ($urandom_range(0, 49) == 0) win_frames = 20'($urandom_range(0, 5));
      enable = en_n;
      cyc(sy, $urandom_range(0, 7) == 0);
    end

    // Asynchronous reset in the middle of a window
    clear = 0; enable = 1; win_frames = 20'd3;
    body(3, 0);
    cyc(1, 1); body(2, 1); cyc(1, 0); body(1, 0);
    #2;
    user_rst_n = 1'b0;
    #1;
    chk("async_reset_word", status_out, 32'h0);
    chk("async_reset_done", {31'b0, win_done}, 32'h0);
    @(negedge user_clk);
    user_rst_n = 1'b1;
    cyc(1, 1);
    for (int k = 0; k < 8; k++) begin
      cyc(1, k[0]); body(2, 0);
    end
    body(4, 0);
    fft_sync = 0; fft_oflow = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
